// File: rtl/spi_byte_bridge.sv
// Byte bridge between a host and an SPI master: TX FIFO -> one-in-flight issue FSM -> RX FIFO.
// Issue one cycle after a write when idle; issue waits for a free RX slot; writes to a full TX FIFO are dropped.

module spi_byte_bridge_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr_ok;
  logic          w_rd_ok;

  // Flags come only from the registered count, never from the request inputs.
  assign o_full    = (r_count == LP_DEPTH);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr_ok   = i_wr_en && !o_full;
  assign w_rd_ok   = i_rd_en && !o_empty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_ok && !w_rd_ok)      r_count <= r_count + 1'b1;
      else if (!w_wr_ok && w_rd_ok) r_count <= r_count - 1'b1;
    end
  end
endmodule

module spi_byte_bridge #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_en,
  output logic          o_tx_full,
  output logic [AW:0]   o_tx_count,
  output logic [7:0]    o_rd_data,
  input  logic          i_rd_en,
  output logic          o_rx_empty,
  output logic [AW:0]   o_rx_count,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  output logic          o_busy,
  output logic          o_rx_err,
  input  logic          i_clr_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RX} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_tx_dv;
  logic [7:0] r_tx_byte;
  logic       r_rx_err;
  logic       w_issue;
  logic       w_rx_push;
  logic       w_err_set;
  logic       w_tx_empty;
  logic       w_rx_full;
  logic [7:0] w_tx_head;

  spi_byte_bridge_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr_en   (i_wr_en),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_issue),
    .o_rd_data (w_tx_head),
    .o_count   (o_tx_count),
    .o_full    (o_tx_full),
    .o_empty   (w_tx_empty)
  );

  spi_byte_bridge_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr_en   (w_rx_push),
    .i_wr_data (i_RX_Byte),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rd_data),
    .o_count   (o_rx_count),
    .o_full    (w_rx_full),
    .o_empty   (o_rx_empty)
  );

  // Issue only with a free RX slot, so the reply push can never be refused.
  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_rx_push = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_err_set = i_RX_DV;
        if (!w_tx_empty && i_TX_Ready && !w_rx_full) begin
          w_issue = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE: begin
        w_err_set = i_RX_DV;
        w_next    = WAIT_RX;
      end
      WAIT_RX: begin
        if (i_RX_DV) begin
          w_rx_push = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_rx_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx_dv <= w_issue;
      if (w_issue) r_tx_byte <= w_tx_head;
      if (w_err_set)      r_rx_err <= 1'b1;
      else if (i_clr_err) r_rx_err <= 1'b0;
    end
  end

  assign o_TX_DV   = r_tx_dv;
  assign o_TX_Byte = r_tx_byte;
  assign o_busy    = (r_state != IDLE);
  assign o_rx_err  = r_rx_err;
endmodule

// File: tb/tb_spi_byte_bridge.sv
// Self-checking bench for spi_byte_bridge: queue-based reference model plus directed scenarios
// against a behavioural loopback SPI master.

module tb_spi_byte_bridge;
  localparam int DEPTH   = 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int SPI_LAT = 20;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic [7:0]    i_wr_data = 8'h00;
  logic          i_wr_en = 1'b0;
  logic          o_tx_full;
  logic [AW:0]   o_tx_count;
  logic [7:0]    o_rd_data;
  logic          i_rd_en = 1'b0;
  logic          o_rx_empty;
  logic [AW:0]   o_rx_count;
  logic [7:0]    o_TX_Byte;
  logic          o_TX_DV;
  logic          i_TX_Ready;
  logic          i_RX_DV;
  logic [7:0]    i_RX_Byte;
  logic          o_busy;
  logic          o_rx_err;
  logic          i_clr_err = 1'b0;

  // SPI-side drive: loopback responder OR a manual stray pulse from the main sequence
  logic          rsp_ready = 1'b1;
  logic          rsp_dv = 1'b0;
  logic [7:0]    rsp_byte = 8'h00;
  logic          man_dv = 1'b0;
  logic [7:0]    man_byte = 8'h00;
  bit            spi_en = 1'b0;
  bit            hold_ready = 1'b0;

  assign i_TX_Ready = rsp_ready;
  assign i_RX_DV    = rsp_dv | man_dv;
  assign i_RX_Byte  = man_dv ? man_byte : rsp_byte;

  int n_checks = 0;
  int n_errs   = 0;
  int dv_count = 0;
  logic [7:0] issued_q[$];

  spi_byte_bridge #(.DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wr_data  (i_wr_data),
    .i_wr_en    (i_wr_en),
    .o_tx_full  (o_tx_full),
    .o_tx_count (o_tx_count),
    .o_rd_data  (o_rd_data),
    .i_rd_en    (i_rd_en),
    .o_rx_empty (o_rx_empty),
    .o_rx_count (o_rx_count),
    .o_TX_Byte  (o_TX_Byte),
    .o_TX_DV    (o_TX_DV),
    .i_TX_Ready (i_TX_Ready),
    .i_RX_DV    (i_RX_DV),
    .i_RX_Byte  (i_RX_Byte),
    .o_busy     (o_busy),
    .o_rx_err   (o_rx_err),
    .i_clr_err  (i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    i_wr_en   = 1'b1;
    i_wr_data = b;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic rd();
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
  endtask

  // Behavioural SPI master: reply with the sent byte SPI_LAT cycles after each issue.
  initial begin : responder
    bit         busy_s;
    int         cnt;
    logic [7:0] held;
    busy_s = 1'b0;
    cnt    = 0;
    held   = 8'h00;
    forever begin
      tick();
      rsp_dv = 1'b0;
      if (o_TX_DV) begin
        dv_count++;
        issued_q.push_back(o_TX_Byte);
        if (spi_en) begin
          busy_s = 1'b1;
          cnt    = SPI_LAT;
          held   = o_TX_Byte;
        end
      end else if (busy_s) begin
        if (cnt == 0) begin
          busy_s   = 1'b0;
          rsp_dv   = 1'b1;
          rsp_byte = held;
        end else begin
          cnt--;
        end
      end
      rsp_ready = !hold_ready && !busy_s;
    end
  end

  // Reference model: FIFOs as queues, one transfer outstanding between issue and reply.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_busy = 1'b0;
  bit         m_dv   = 1'b0;
  bit         m_err  = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge i_clk or negedge i_reset_n) begin : model
    bit can_issue;
    bit accept;
    bit tx_room;
    if (!i_reset_n) begin
      m_tx.delete();
      m_rx.delete();
      m_busy = 1'b0;
      m_dv   = 1'b0;
      m_err  = 1'b0;
      m_byte = 8'h00;
    end else begin
      can_issue = !m_busy && (m_tx.size() > 0) && i_TX_Ready && (m_rx.size() < DEPTH);
      accept    = i_RX_DV && m_busy && !m_dv;
      tx_room   = m_tx.size() < DEPTH;
      if (i_rd_en && m_rx.size() > 0) void'(m_rx.pop_front());
      if (accept) begin
        m_rx.push_back(i_RX_Byte);
        m_busy = 1'b0;
      end
      if (i_RX_DV && !accept) m_err = 1'b1;
      else if (i_clr_err)     m_err = 1'b0;
      if (can_issue) begin
        m_byte = m_tx.pop_front();
        m_busy = 1'b1;
      end
      m_dv = can_issue;
      if (i_wr_en && tx_room) m_tx.push_back(i_wr_data);
    end
  end

  always @(negedge i_clk) begin : compare
    chk("m_tx_count", 32'(o_tx_count), m_tx.size());
    chk("m_tx_full",  32'(o_tx_full),  32'(m_tx.size() == DEPTH));
    chk("m_rx_count", 32'(o_rx_count), m_rx.size());
    chk("m_rx_empty", 32'(o_rx_empty), 32'(m_rx.size() == 0));
    chk("m_TX_DV",    32'(o_TX_DV),    32'(m_dv));
    chk("m_TX_Byte",  32'(o_TX_Byte),  32'(m_byte));
    chk("m_busy",     32'(o_busy),     32'(m_busy));
    chk("m_rx_err",   32'(o_rx_err),   32'(m_err));
    if (m_rx.size() > 0) chk("m_rd_data", 32'(o_rd_data), 32'(m_rx[0]));
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs + 1);
    $fatal(1);
  end

  initial begin : main
    logic [7:0] burst [3];
    int base;
    burst[0] = 8'hBE;
    burst[1] = 8'hEF;
    burst[2] = 8'h5A;

    // Reset values
    repeat (3) tick();
    chk("rst_rx_empty", 32'(o_rx_empty), 32'd1);
    chk("rst_busy",     32'(o_busy),     32'd0);
    chk("rst_TX_DV",    32'(o_TX_DV),    32'd0);
    chk("rst_TX_Byte",  32'(o_TX_Byte),  32'h00);
    chk("rst_tx_count", 32'(o_tx_count), 32'd0);
    chk("rst_rx_count", 32'(o_rx_count), 32'd0);
    chk("rst_tx_full",  32'(o_tx_full),  32'd0);
    chk("rst_rd_data",  32'(o_rd_data),  32'h00);
    chk("rst_rx_err",   32'(o_rx_err),   32'd0);
    i_reset_n = 1'b1;
    spi_en    = 1'b1;
    repeat (2) tick();

    // Single byte: issue one cycle after the write, reply lands in RX FIFO
    wr(8'hC1);
    chk("single_tx_count", 32'(o_tx_count), 32'd1);
    chk("single_no_dv_yet", 32'(o_TX_DV), 32'd0);
    tick();
    chk("single_dv",   32'(o_TX_DV),   32'd1);
    chk("single_byte", 32'(o_TX_Byte), 32'hC1);
    chk("single_busy", 32'(o_busy),    32'd1);
    tick();
    chk("single_dv_width", 32'(o_TX_DV), 32'd0);
    for (int k = 0; k < 100 && o_rx_count == 0; k++) tick();
    chk("single_rx_count", 32'(o_rx_count), 32'd1);
    chk("single_rd_data",  32'(o_rd_data),  32'hC1);
    chk("single_dv_count", dv_count,        32'd1);
    rd();
    chk("single_drained", 32'(o_rx_empty), 32'd1);

    // Burst ordering
    for (int i = 0; i < 3; i++) wr(burst[i]);
    for (int k = 0; k < 300 && o_rx_count != 3; k++) tick();
    chk("burst_dv_count", dv_count, 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("burst_issue_order", 32'(issued_q[i+1]), 32'(burst[i]));
      chk("burst_rd_data", 32'(o_rd_data), 32'(burst[i]));
      rd();
    end
    chk("burst_empty", 32'(o_rx_empty), 32'd1);

    // TX overflow with ready held low
    hold_ready = 1'b1;
    repeat (2) tick();
    base = dv_count;
    for (int i = 0; i < 9; i++) wr(8'(i));
    chk("ovf_full",  32'(o_tx_full),  32'd1);
    chk("ovf_count", 32'(o_tx_count), 32'd8);
    chk("ovf_no_issue", dv_count - base, 32'd0);
    hold_ready = 1'b0;
    for (int k = 0; k < 600 && o_rx_count != 8; k++) tick();
    chk("ovf_issued", dv_count - base, 32'd8);
    chk("ovf_tx_left", 32'(o_tx_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_issue_order", 32'(issued_q[base+i]), 32'(i));
      chk("ovf_rd_data", 32'(o_rd_data), 32'(i));
      rd();
    end

    // RX backpressure: no reads, 10 bytes offered
    base = dv_count;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 200 && o_tx_full; k++) tick();
      wr(8'h10 + 8'(i));
    end
    for (int k = 0; k < 600 && o_rx_count != 8; k++) tick();
    repeat (40) tick();
    chk("bp_rx_count", 32'(o_rx_count), 32'd8);
    chk("bp_issued",   dv_count - base, 32'd8);
    chk("bp_tx_count", 32'(o_tx_count), 32'd2);
    chk("bp_idle",     32'(o_busy),     32'd0);
    chk("bp_no_dv",    32'(o_TX_DV),    32'd0);
    chk("bp_head",     32'(o_rd_data),  32'h10);
    rd();
    for (int k = 0; k < 100 && o_rx_count != 8; k++) tick();
    repeat (40) tick();
    chk("bp_one_more", dv_count - base, 32'd9);
    chk("bp_tx_count2", 32'(o_tx_count), 32'd1);
    for (int k = 0; k < 800 && (o_rx_count != 0 || o_tx_count != 0 || o_busy); k++) begin
      i_rd_en = (o_rx_count != 0);
      tick();
    end
    i_rd_en = 1'b0;
    chk("bp_all_issued", dv_count - base, 32'd10);
    chk("bp_drained", 32'(o_rx_empty), 32'd1);

    // Stray RX_DV in IDLE, clear, and set-wins-over-clear
    spi_en   = 1'b0;
    man_byte = 8'hAA;
    man_dv   = 1'b1;
    tick();
    man_dv   = 1'b0;
    chk("err_set",      32'(o_rx_err),   32'd1);
    chk("err_rx_count", 32'(o_rx_count), 32'd0);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("err_clr", 32'(o_rx_err), 32'd0);
    man_dv    = 1'b1;
    i_clr_err = 1'b1;
    tick();
    man_dv    = 1'b0;
    chk("err_set_wins", 32'(o_rx_err), 32'd1);
    tick();
    i_clr_err = 1'b0;
    chk("err_clr2", 32'(o_rx_err), 32'd0);

    // Reset asserted in WAIT_RX
    spi_en = 1'b1;
    wr(8'h77);
    wr(8'h78);
    repeat (3) tick();
    chk("mid_busy",  32'(o_busy),  32'd1);
    chk("mid_no_dv", 32'(o_TX_DV), 32'd0);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",     32'(o_busy),     32'd0);
    chk("mid_rst_tx_count", 32'(o_tx_count), 32'd0);
    chk("mid_rst_TX_Byte",  32'(o_TX_Byte),  32'h00);
    chk("mid_rst_rx_empty", 32'(o_rx_empty), 32'd1);
    tick();
    i_reset_n = 1'b1;
    repeat (40) tick();
    chk("mid_late_rx_dropped", 32'(o_rx_count), 32'd0);
    chk("mid_late_idle",       32'(o_busy),     32'd0);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("mid_err_cleared", 32'(o_rx_err), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
